// File: rtl/mac_window_pkg.sv
// Shared types and width helpers for the sliding-window multiply-add pipeline.
package mac_window_pkg;

   typedef enum logic [1:0] {
      MODE_MAC = 2'd0,
      MODE_SUM = 2'd1,
      MODE_ACC = 2'd2,
      MODE_RSV = 2'd3
   } mode_e;

   localparam int unsigned DefaultDw   = 32;
   localparam int unsigned DefaultVlen = 3;

   // Internal width holds a*b+c plus a clamped accumulator without loss.
   function automatic int unsigned int_width(input int unsigned dw);
      return 2 * dw + 2;
   endfunction

endpackage

// File: rtl/mac_window_arith.sv
// Combinational window arithmetic: MAC/SUM/ACC result with saturate-or-wrap mapping.
module mac_window_arith
   import mac_window_pkg::*;
#(
   parameter int unsigned DW = DefaultDw
) (
   input  logic [DW-1:0]     a_i,
   input  logic [DW-1:0]     b_i,
   input  logic [DW-1:0]     c_i,
   input  logic [2*DW+1:0]   acc_i,
   input  mode_e             mode_i,
   input  logic              sat_i,
   output logic [DW-1:0]     result_o,
   output logic              ovf_o,
   output logic [2*DW+1:0]   acc_next_o
);

   localparam int unsigned IW = int_width(DW);
   // 2^DW: overflow threshold and sticky accumulator ceiling.
   localparam logic [IW-1:0] Limit = {{(IW-DW-1){1'b0}}, 1'b1, {DW{1'b0}}};

   logic [IW-1:0] prod;
   logic [IW-1:0] mac;
   logic [IW-1:0] sum;
   logic [IW-1:0] acc_sum;
   logic [IW-1:0] full;

   always_comb begin
      prod       = IW'(a_i) * IW'(b_i);
      mac        = prod + IW'(c_i);
      sum        = IW'(a_i) + IW'(b_i) + IW'(c_i);
      acc_sum    = acc_i + mac;
      acc_next_o = (acc_sum >= Limit) ? Limit : acc_sum;
      full       = mac;
      case (mode_i)
         MODE_SUM: full = sum;
         MODE_ACC: full = acc_next_o;
         default:  full = mac;
      endcase
      ovf_o    = (full >= Limit);
      result_o = (ovf_o && sat_i) ? {DW{1'b1}} : full[DW-1:0];
   end

endmodule

// File: rtl/mac_window_pipe.sv
// Sliding three-sample window over consecutive valid inputs with run-length qualification
// and a one-cycle registered result.
module mac_window_pipe
   import mac_window_pkg::*;
#(
   parameter int unsigned DW   = DefaultDw,
   parameter int unsigned VLEN = DefaultVlen
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          validi,
   input  logic [DW-1:0] data_in,
   input  logic [1:0]    mode,
   input  logic          sat,
   output logic          valido,
   output logic [DW-1:0] data_out,
   output logic          ovf
);

   localparam int unsigned IW = int_width(DW);
   localparam int unsigned CW = $clog2(VLEN + 1);

   logic [DW-1:0] d1_q;
   logic [DW-1:0] d2_q;
   logic [CW-1:0] cnt_q;
   logic [IW-1:0] acc_q;
   logic          valid_q;
   logic [DW-1:0] data_q;
   logic          ovf_q;

   mode_e         mode_s;
   logic          fire;
   logic [DW-1:0] result;
   logic          res_ovf;
   logic [IW-1:0] acc_next;

   assign mode_s = mode_e'(mode);
   // A window fires on the VLEN-th consecutive valid sample and every valid one after.
   assign fire   = validi && (cnt_q >= CW'(VLEN - 1));

   mac_window_arith #(
      .DW(DW)
   ) u_arith (
      .a_i       (d2_q),
      .b_i       (d1_q),
      .c_i       (data_in),
      .acc_i     (acc_q),
      .mode_i    (mode_s),
      .sat_i     (sat),
      .result_o  (result),
      .ovf_o     (res_ovf),
      .acc_next_o(acc_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         d1_q    <= '0;
         d2_q    <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (validi) begin
            d2_q  <= d1_q;
            d1_q  <= data_in;
            cnt_q <= (cnt_q == CW'(VLEN)) ? cnt_q : cnt_q + CW'(1);
         end else begin
            cnt_q <= '0;
         end
         // Leaving ACC or breaking the run restarts the accumulation from zero.
         if (!validi || mode_s != MODE_ACC) begin
            acc_q <= '0;
         end else if (fire) begin
            acc_q <= acc_next;
         end
         valid_q <= fire;
         data_q  <= fire ? result : '0;
         ovf_q   <= fire && res_ovf;
      end
   end

   assign valido   = valid_q;
   assign data_out = data_q;
   assign ovf      = ovf_q;

endmodule
